// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction memory window, reset PC.
package cpu_pkg;

    // Fetch FSM states; the encoding is also what fetch_ctrl puts on dbg_state.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,  // request outstanding
        S_HOLD  = 2'd1,  // instruction buffered while decode stalls
        S_FLUSH = 2'd2   // request outstanding, its response will be dropped
    } fetch_state_e;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IMEM_LIMIT = 32'h0000_6FFC;
    localparam logic [31:0] NOP        = 32'h0000_0000;

endpackage

// File: rtl/fetch_addr_chk.sv
// Word-aligned address window check. Purely combinational so the same block
// can serve the data-side load/store address check.
module fetch_addr_chk #(
    parameter logic [31:0] BASE  = cpu_pkg::IMEM_BASE,
    parameter logic [31:0] LIMIT = cpu_pkg::IMEM_LIMIT
) (
    input  logic [31:0] i_addr,
    output logic        o_err
);

    logic w_misaligned;
    logic w_out_of_range;

    // Flag any address that is not word aligned or falls outside [BASE, LIMIT].
    always_comb begin
        w_misaligned   = (i_addr[1:0] != 2'b00);
        w_out_of_range = (i_addr < BASE) || (i_addr > LIMIT);
        o_err          = w_misaligned || w_out_of_range;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the instruction memory request, holds
// the fetched word while decode stalls, and drops the in-flight response when
// a redirect arrives before memory has answered.
//
// Handshake: imem_req/imem_addr stay stable while a fetch is outstanding; a
// fetch completes in the cycle imem_ready=1 (imem_rdata valid only then), or
// immediately when the address is illegal (no request is issued for it).
// f_valid marks f_instr/f_pc/f_adel for the F/D register in the same cycle.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
    parameter logic [31:0] IMEM_BASE  = cpu_pkg::IMEM_BASE,
    parameter logic [31:0] IMEM_LIMIT = cpu_pkg::IMEM_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] f_pc,
    output logic [31:0] f_instr,
    output logic        f_valid,
    output logic        f_adel,
    output logic [1:0]  dbg_state
);

    import cpu_pkg::*;

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_pend_pc;
    logic [31:0]  r_hold_instr;
    logic         r_hold_adel;

    logic         w_pc_err;
    logic         w_resp;
    logic [31:0]  w_fetch_instr;

    fetch_addr_chk #(
        .BASE  (IMEM_BASE),
        .LIMIT (IMEM_LIMIT)
    ) u_addr_chk (
        .i_addr (r_pc),
        .o_err  (w_pc_err)
    );

    // An illegal address completes at once with a NOP instead of waiting on memory.
    always_comb begin
        w_resp        = imem_ready || w_pc_err;
        w_fetch_instr = w_pc_err ? NOP : imem_rdata;
    end

    // Output decode; redirect suppresses f_valid in every state.
    always_comb begin
        imem_req = 1'b0;
        f_valid  = 1'b0;
        f_instr  = NOP;
        f_adel   = w_pc_err;
        case (r_state)
            S_REQ: begin
                imem_req = !w_pc_err;
                f_valid  = w_resp && !redirect;
                f_instr  = w_fetch_instr;
            end
            S_HOLD: begin
                f_valid  = !redirect;
                f_instr  = r_hold_instr;
                f_adel   = r_hold_adel;
            end
            S_FLUSH: begin
                imem_req = !w_pc_err;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign imem_addr = r_pc;
    assign f_pc      = r_pc;
    assign dbg_state = r_state;

    // FSM and PC update; redirect outranks stall and npc in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_pend_pc    <= 32'h0;
            r_hold_instr <= 32'h0;
            r_hold_adel  <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (redirect) begin
                        if (w_resp) begin
                            r_pc <= redirect_pc;
                        end else begin
                            // Memory still owes us a word for r_pc; keep the
                            // address stable and park the target until it lands.
                            r_pend_pc <= redirect_pc;
                            r_state   <= S_FLUSH;
                        end
                    end else if (w_resp) begin
                        if (stall) begin
                            r_hold_instr <= w_fetch_instr;
                            r_hold_adel  <= w_pc_err;
                            r_state      <= S_HOLD;
                        end else begin
                            r_pc <= npc;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        r_pc    <= redirect_pc;
                        r_state <= S_REQ;
                    end else if (!stall) begin
                        r_pc    <= npc;
                        r_state <= S_REQ;
                    end
                end
                S_FLUSH: begin
                    if (imem_ready) begin
                        r_pc    <= redirect ? redirect_pc : r_pend_pc;
                        r_state <= S_REQ;
                    end else if (redirect) begin
                        r_pend_pc <= redirect_pc;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with fixed expected
// values, then randomized traffic against a behavioural fetch model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_valid;
    logic        f_adel;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .npc         (npc),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .f_pc        (f_pc),
        .f_instr     (f_instr),
        .f_valid     (f_valid),
        .f_adel      (f_adel),
        .dbg_state   (dbg_state)
    );

    // ---------------- behavioural model ----------------
    // The model tracks the address on the bus, whether a word is parked for a
    // stalled decode, and whether the in-flight response is to be thrown away.
    logic [31:0] m_pc;
    logic        m_held;
    logic [31:0] m_hword;
    logic        m_herr;
    logic        m_drop;
    logic [31:0] m_target;

    logic [31:0] e_pc;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_adel;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
    endfunction

    task automatic model_reset();
        m_pc = 32'h3000; m_held = 1'b0; m_hword = 32'h0; m_herr = 1'b0;
        m_drop = 1'b0; m_target = 32'h0;
    endtask

    task automatic model_expect();
        logic got;
        e_pc = m_pc;
        e_instr = 32'h0;
        e_adel = 1'b0;
        if (m_drop) begin
            e_valid = 1'b0;
            e_req = 1'b1;
        end else if (m_held) begin
            e_valid = !redirect;
            e_req = 1'b0;
            e_instr = m_hword;
            e_adel = m_herr;
        end else begin
            got = imem_ready || addr_bad(m_pc);
            e_valid = got && !redirect;
            e_req = !addr_bad(m_pc);
            e_instr = addr_bad(m_pc) ? 32'h0 : mem_word(m_pc);
            e_adel = addr_bad(m_pc);
        end
    endtask

    task automatic model_update();
        logic got;
        if (reset) begin
            model_reset();
            return;
        end
        got = !m_drop && !m_held && (imem_ready || addr_bad(m_pc));
        if (redirect) begin
            if (m_drop) begin
                if (imem_ready) begin m_pc = redirect_pc; m_drop = 1'b0; end
                else m_target = redirect_pc;
            end else if (m_held || got) begin
                m_pc = redirect_pc; m_held = 1'b0;
            end else begin
                m_drop = 1'b1; m_target = redirect_pc;
            end
        end else if (m_drop) begin
            if (imem_ready) begin m_pc = m_target; m_drop = 1'b0; end
        end else if (m_held) begin
            if (!stall) begin m_pc = npc; m_held = 1'b0; end
        end else if (got) begin
            if (stall) begin
                m_held = 1'b1;
                m_herr = addr_bad(m_pc);
                m_hword = addr_bad(m_pc) ? 32'h0 : mem_word(m_pc);
            end else begin
                m_pc = npc;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Memory returns the model's word only for a live fetch; otherwise junk,
    // so a held instruction can only come from the DUT's own buffer.
    task automatic drive(input logic [31:0] n, input logic st, input logic rd,
                         input logic [31:0] rpc, input logic rdy);
        npc = n; stall = st; redirect = rd; redirect_pc = rpc; imem_ready = rdy;
        imem_rdata = (rdy && !m_held && !m_drop) ? mem_word(m_pc) : $urandom;
    endtask

    task automatic settle();
        @(negedge clk);
        model_expect();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [31:0] pick_addr(input logic [31:0] seq);
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 6) return seq;
        if (sel == 6) return 32'h3000 + ($urandom_range(0, 4095) << 2);
        if (sel == 7) begin
            case ($urandom_range(0, 3))
                0: return 32'h6FFC;
                1: return 32'h7000;
                2: return 32'h2FFC;
                default: return 32'h3000;
            endcase
        end
        if (sel == 8) return 32'h3000 + ($urandom_range(0, 4095) << 2) + $urandom_range(1, 3);
        return $urandom;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        advance();
        settle();
        n_checks++;
        if (f_pc !== 32'h3000) begin n_errors++; $display("FAIL reset_pc got=%h exp=%h", f_pc, 32'h3000); end
        n_checks++;
        if (dbg_state !== 2'(cpu_pkg::S_REQ)) begin n_errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, 0); end
        n_checks++;
        if (f_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", f_valid); end
        advance();
        reset = 1'b0;
        drive(32'h3004, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
            n_errors++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=00003000", imem_req, imem_addr);
        end
        advance();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc = '{32'h3000, 32'h3004, 32'h3008};
        for (int i = 0; i < 3; i++) begin
            drive(m_pc + 32'd4, 1'b0, 1'b0, 32'h0, 1'b1);
            settle();
            n_checks++;
            if (f_pc !== exp_pc[i] || f_valid !== 1'b1 || f_instr !== mem_word(exp_pc[i])) begin
                n_errors++;
                $display("FAIL seq_fetch[%0d] got pc=%h v=%b ins=%h exp pc=%h v=1 ins=%h",
                         i, f_pc, f_valid, f_instr, exp_pc[i], mem_word(exp_pc[i]));
            end
            advance();
        end
    endtask

    task automatic test_stall_hold();
        drive(32'h3010, 1'b0, 1'b0, 32'h0, 1'b1);
        settle();
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(32'h3010 + 32'd4, 1'b1, 1'b0, 32'h0, 1'b1);
            settle();
            n_checks++;
            if (f_pc !== 32'h3010 || f_valid !== 1'b1 || f_instr !== mem_word(32'h3010)) begin
                n_errors++;
                $display("FAIL stall_hold[%0d] got pc=%h v=%b ins=%h exp pc=00003010 v=1 ins=%h",
                         i, f_pc, f_valid, f_instr, mem_word(32'h3010));
            end
            if (i > 0) begin
                n_checks++;
                if (imem_req !== 1'b0) begin n_errors++; $display("FAIL hold_req[%0d] got=%b exp=0", i, imem_req); end
            end
            advance();
        end
        drive(32'h3014, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        n_checks++;
        if (f_valid !== 1'b1 || f_instr !== mem_word(32'h3010)) begin
            n_errors++; $display("FAIL hold_release got v=%b ins=%h exp v=1 ins=%h", f_valid, f_instr, mem_word(32'h3010));
        end
        advance();
        drive(32'h3018, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        n_checks++;
        if (f_pc !== 32'h3014) begin n_errors++; $display("FAIL hold_advance got=%h exp=00003014", f_pc); end
        advance();
    endtask

    task automatic test_redirect_flush();
        drive(32'h3020, 1'b0, 1'b0, 32'h0, 1'b1);
        settle();
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(32'h3024, 1'b0, (i == 0), 32'h4180, (i == 2));
            settle();
            n_checks++;
            if (f_valid !== 1'b0 || imem_addr !== 32'h3020) begin
                n_errors++;
                $display("FAIL flush[%0d] got v=%b addr=%h exp v=0 addr=00003020", i, f_valid, imem_addr);
            end
            advance();
        end
        drive(32'h4184, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        n_checks++;
        if (imem_addr !== 32'h4180 || imem_req !== 1'b1) begin
            n_errors++; $display("FAIL flush_target got addr=%h req=%b exp addr=00004180 req=1", imem_addr, imem_req);
        end
        advance();
    endtask

    task automatic test_adel();
        drive(32'h3002, 1'b0, 1'b0, 32'h0, 1'b1);
        settle();
        advance();
        drive(32'h3100, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        n_checks++;
        if (imem_req !== 1'b0 || f_valid !== 1'b1 || f_adel !== 1'b1 || f_instr !== 32'h0) begin
            n_errors++;
            $display("FAIL adel got req=%b v=%b adel=%b ins=%h exp req=0 v=1 adel=1 ins=00000000",
                     imem_req, f_valid, f_adel, f_instr);
        end
        advance();
    endtask

    task automatic test_double_redirect();
        drive(32'h3200, 1'b0, 1'b0, 32'h0, 1'b1);
        settle();
        advance();
        drive(32'h3204, 1'b0, 1'b1, 32'h4180, 1'b0);
        settle();
        advance();
        drive(32'h3204, 1'b0, 1'b1, 32'h3100, 1'b1);
        settle();
        n_checks++;
        if (f_valid !== 1'b0) begin n_errors++; $display("FAIL dbl_redirect_valid got=%b exp=0", f_valid); end
        advance();
        drive(32'h3104, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        n_checks++;
        if (f_pc !== 32'h3100) begin n_errors++; $display("FAIL dbl_redirect_pc got=%h exp=00003100", f_pc); end
        advance();
    endtask

    task automatic test_reset_in_flush();
        drive(32'h3104, 1'b0, 1'b1, 32'h4180, 1'b0);
        settle();
        advance();
        drive(32'h3104, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        reset = 1'b1;
        #1;
        n_checks++;
        if (f_pc !== 32'h3000 || dbg_state !== 2'(cpu_pkg::S_REQ)) begin
            n_errors++; $display("FAIL async_reset got pc=%h st=%0d exp pc=00003000 st=0", f_pc, dbg_state);
        end
        advance();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h3004, 1'b0, 1'b0, 32'h0, (i == 2));
            settle();
            n_checks++;
            if (f_valid !== (i == 2) || f_pc !== 32'h3000) begin
                n_errors++; $display("FAIL post_reset[%0d] got v=%b pc=%h exp v=%b pc=00003000", i, f_valid, f_pc, (i == 2));
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic rd;
        for (int i = 0; i < 500; i++) begin
            rd = ($urandom_range(0, 7) == 0);
            drive(pick_addr(m_pc + 32'd4), ($urandom_range(0, 3) == 0), rd,
                  pick_addr(32'h3000 + ($urandom_range(0, 4095) << 2)), $urandom_range(0, 1) == 1);
            settle();
            n_checks++;
            if (f_pc !== e_pc || imem_addr !== e_pc || imem_req !== e_req || f_valid !== e_valid) begin
                n_errors++;
                $display("FAIL rand_ctl[%0d] got pc=%h addr=%h req=%b v=%b exp pc=%h req=%b v=%b",
                         i, f_pc, imem_addr, imem_req, f_valid, e_pc, e_req, e_valid);
            end
            if (e_valid) begin
                n_checks++;
                if (f_instr !== e_instr || f_adel !== e_adel) begin
                    n_errors++;
                    $display("FAIL rand_data[%0d] got ins=%h adel=%b exp ins=%h adel=%b",
                             i, f_instr, f_adel, e_instr, e_adel);
                end
            end
            advance();
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_redirect_flush();
        test_adel();
        test_double_redirect();
        test_reset_in_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: first fetch address after reset.
REQ-002 Parameter IMEM_BASE, default 32'h0000_3000: lowest legal fetch address.
REQ-003 Parameter IMEM_LIMIT, default 32'h0000_6FFC: highest legal fetch address, inclusive.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 npc  in  32  sequential/branch/jump target from the decode-stage next-PC unit.
REQ-007 stall  in  1  decode-stage hazard stall; F/D register holds.
REQ-008 redirect  in  1  exception entry or eret; overrides npc and stall.
REQ-009 redirect_pc  in  32  exception handler base or return target.
REQ-010 imem_ready  in  1  instruction memory response valid this cycle.
REQ-011 imem_rdata  in  32  instruction word; valid only when imem_ready=1.
REQ-012 imem_req  out  1  fetch request to instruction memory.
REQ-013 imem_addr  out  32  fetch address; always equals f_pc.
REQ-014 f_pc  out  32  PC of the instruction being fetched or held.
REQ-015 f_instr  out  32  instruction presented to the F/D register.
REQ-016 f_valid  out  1  f_instr/f_pc are valid this cycle.
REQ-017 f_adel  out  1  fetch address error for f_pc; qualified by f_valid.

Function
REQ-018 Three states SHALL exist: S_REQ (request outstanding), S_HOLD (instruction buffered under stall), S_FLUSH (request outstanding, response to be discarded).
REQ-019 imem_req SHALL be 1 in S_REQ and S_FLUSH when f_adel=0, and 0 in all other cases.
REQ-020 f_adel SHALL be 1 when f_pc[1:0]!=0, f_pc<IMEM_BASE or f_pc>IMEM_LIMIT.
REQ-021 The S_REQ response condition SHALL be imem_ready=1 or f_adel=1; an address error completes in zero wait cycles with f_instr=32'h0.
REQ-022 S_REQ with response and no redirect SHALL give f_valid=1 and f_instr=imem_rdata (or 0 on f_adel), both combinational in the same cycle.
REQ-023 In that case with stall=0: f_pc<=npc, stay S_REQ.
REQ-024 In that case with stall=1: instruction and f_adel are latched into a hold buffer, go S_HOLD, f_pc unchanged.
REQ-025 S_REQ with no response and no redirect: no state change; stall SHALL be ignored.
REQ-026 S_HOLD: f_valid=1, f_instr=buffer, f_adel=buffered flag; on stall=0 with no redirect: f_pc<=npc, go S_REQ.
REQ-027 Redirect in S_REQ with response, or in S_HOLD: f_valid=0, f_pc<=redirect_pc, go S_REQ.
REQ-028 Redirect in S_REQ without response: f_valid=0, pending_pc<=redirect_pc, go S_FLUSH; imem_addr SHALL stay at the outstanding address.
REQ-029 S_FLUSH: f_valid=0 always; on imem_ready: f_pc<=pending_pc, go S_REQ.
REQ-030 A further redirect in S_FLUSH SHALL overwrite pending_pc; on the same cycle as imem_ready the new redirect_pc SHALL win.
REQ-031 Redirect SHALL take priority over stall and npc in every state.
REQ-032 Back-to-back fetches SHALL sustain one instruction per cycle when imem_ready is held at 1 and stall=0.

Reset
REQ-033 During reset: state=S_REQ, f_pc=RESET_PC, pending_pc=0, hold buffer=0, buffered f_adel=0.
REQ-034 Reset asserted mid-request SHALL abandon the request; instruction memory is reset by the same signal.
REQ-035 The first request SHALL issue in the first cycle after reset deasserts.

Structure
REQ-036 Shared package cpu_pkg SHALL hold the state enum, RESET_PC, IMEM_BASE, IMEM_LIMIT and the NOP constant.
REQ-037 The address-range/alignment check SHALL be a sub-module fetch_addr_chk (combinational, reusable by the data-side address check).

Verification
REQ-038 Reset, then imem_ready=1 each cycle, npc=f_pc+4 -> f_pc goes 0x3000, 0x3004, 0x3008 with f_valid=1 every cycle.
REQ-039 imem_ready=1 with stall=1 for 3 cycles at 0x3010 -> f_valid=1, f_instr constant, imem_req=0 during hold, f_pc=0x3010, then advances to npc.
REQ-040 imem_ready=0 at 0x3020, then redirect with redirect_pc=0x4180, imem_ready at +2 cycles -> f_valid=0 throughout, next imem_addr=0x4180.
REQ-041 npc=0x3002 (misaligned) -> imem_req=0, f_valid=1, f_adel=1, f_instr=0 in the same cycle.
REQ-042 Two redirects in S_FLUSH (0x4180, then 0x3100 on the cycle imem_ready=1) -> next f_pc=0x3100.
REQ-043 reset pulse while in S_FLUSH -> state S_REQ, f_pc=0x3000, f_valid=0 until the first response.
